mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Sequences MEM-stage data-memory accesses for the pipelined RV32I core. It sits between the EX/MEM pipeline register outputs and a variable-latency data memory using a req/ack handshake.
- Generates byte enables, store-lane replication, load extraction and extension, and misalignment detection.
- Drives StallM, which freezes the F/D/E/M pipeline registers while an access is outstanding.

Parameters:
- DATA_WIDTH, 32, data and address width (only 32 supported).
- TIMEOUT_CYCLES, 255, maximum WAIT cycles without mem_ack before a bus error is flagged (≥1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ResultSrcM  in  2  2'b01 marks a load.
- MemWriteM  in  1  store request.
- ALUResultM  in  32  byte address.
- WriteDataM  in  32  store data (rs2).
- AddressingControlM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- mem_req  out  1  registered bus request.
- mem_we  out  1  registered write enable.
- mem_addr  out  32  registered word address ({ALUResultM[31:2],2'b00}).
- mem_wdata  out  32  registered lane-replicated store data.
- mem_be  out  4  registered byte enables.
- mem_ack  in  1  memory completion; rdata valid in the same cycle.
- mem_rdata  in  32  read word.
- StallM  out  1  combinational stall to pipeline registers.
- ReadDataM  out  32  registered, extended load result.
- MisalignM  out  1  one-cycle misaligned-access flag.
- BusErrorM  out  1  one-cycle timeout flag.

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE. mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadDataM, MisalignM, BusErrorM and the timeout counter all go to 0. StallM=0 while in IDLE with no access.
- Reset mid-transaction abandons the access; no retry.
- access = MemWriteM | (ResultSrcM==2'b01). MemWriteM has priority if both are set (treated as a store).
- aligned:
  - H/HU require addr[0]=0.
  - W requires addr[1:0]=0.
  - B/BU are always aligned.
  - Undefined funct3 (011, 110, 111) is treated as W.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - access & aligned: StallM=1 (combinational). At the edge, register mem_req=1, mem_we, mem_addr, mem_be, mem_wdata, clear the counter, go to WAIT.
  - access & !aligned: no request, StallM=0, MisalignM=1 for the next cycle only. Store is suppressed. ReadDataM is unchanged. Stay in IDLE.
- WAIT:
  - StallM=1, mem_req held, counter increments each cycle.
  - mem_ack=1 at an edge: mem_req←0, mem_we←0. For loads, ReadDataM←extended mem_rdata. Go to DONE.
  - No ack and counter==TIMEOUT_CYCLES-1: mem_req←0, ReadDataM←0 for loads, BusErrorM←1. Go to DONE.
  - Ack in the expiry cycle wins; no error.
- DONE:
  - StallM=0, so the pipeline advances at this edge.
  - BusErrorM/MisalignM clear at the next edge. Go to IDLE unconditionally.
  - The next instruction is evaluated in IDLE.
- Timing:
  - Minimum access (ack in first WAIT cycle) = 2 stall cycles.
  - Total = ack latency + 2 cycles per access.
  - Back-to-back accesses pass through DONE→IDLE with no overlap.
- Store lanes:
  - SB: wdata={4{WriteDataM[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{WriteDataM[15:0]}}, be=4'b0011<<{addr[1],1'b0}.
  - SW: be=4'b1111.
  - Loads: be=4'b1111, mem_we=0.
- Load extraction:
  - B: byte at addr[1:0], sign-extended.
  - BU: zero-extended.
  - H/HU: halfword at addr[1], sign- or zero-extended.
  - W: full word.
- ReadDataM holds its value until the next load completes; it is ignored for stores.
- Non-access cycles in IDLE: StallM=0, outputs hold, mem_req=0.

Test Plan:
- LW at addr 0x100, ack after 3 WAIT cycles, mem_rdata=0xDEADBEEF → mem_addr=0x100, be=1111, StallM high 4 cycles, ReadDataM=0xDEADBEEF in DONE.
- LB at addr 0x103, mem_rdata=0x80FF_0000, ack immediate → ReadDataM=0xFFFFFF80. Same access as LBU → 0x00000080. StallM high exactly 2 cycles.
- SH at addr 0x22, WriteDataM=0x1234ABCD → mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD. ReadDataM unchanged.
- LW at addr 0x101 → no mem_req, MisalignM=1 for one cycle, StallM=0. SH at 0x23 → same response, no write issued.
- TIMEOUT_CYCLES=4, no ack → mem_req dropped after 4 WAIT cycles, BusErrorM=1 for one cycle, ReadDataM=0. Rerun with ack on the 4th cycle → no error.
- rst_n=0 during WAIT → next cycle state=IDLE, mem_req=0, StallM=0, all outputs 0. A subsequent LW completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Data-memory bus between the MEM-stage access controller and a variable-latency memory.
// req is held until ack; rdata is valid in the ack cycle.
interface mem_access_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    mem_req;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic                    mem_ack;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory sequencer: byte lanes, load extension, misalign detection,
// req/ack handshake with timeout, and the StallM freeze for the upstream pipeline.
module mem_access_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [2:0]            AddressingControlM,
  mem_access_ctrl_if.master     bus,
  output logic                  StallM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  MisalignM,
  output logic                  BusErrorM
);
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt;
  logic                    ld_q;
  logic [2:0]              f3_q;
  logic [1:0]              off_q;

  logic                    is_store, is_load, access, aligned, issue, expired;
  logic [1:0]              off, sz;
  logic [DATA_WIDTH/8-1:0] be_nxt;
  logic [DATA_WIDTH-1:0]   wdata_nxt, rdata_ext;
  logic [7:0]              lbyte;
  logic [15:0]             lhalf;

  // A store wins when both store and load are flagged.
  assign is_store = MemWriteM;
  assign is_load  = !MemWriteM && (ResultSrcM == 2'b01);
  assign access   = is_store || is_load;
  assign off      = ALUResultM[1:0];
  // funct3[1:0]: 00 byte, 01 half, anything else is a word (covers 011/110/111).
  assign sz       = AddressingControlM[1:0];
  assign expired  = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    aligned = 1'b1;
    case (sz)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = !off[0];
      default: aligned = (off == 2'b00);
    endcase
  end

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = WriteDataM;
    if (is_store) begin
      case (sz)
        2'b00: begin
          be_nxt    = 4'b0001 << off;
          wdata_nxt = {4{WriteDataM[7:0]}};
        end
        2'b01: begin
          be_nxt    = 4'b0011 << {off[1], 1'b0};
          wdata_nxt = {2{WriteDataM[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Extraction uses the captured funct3/offset so it never depends on stalled inputs.
  always_comb begin
    case (off_q)
      2'd0:    lbyte = bus.mem_rdata[7:0];
      2'd1:    lbyte = bus.mem_rdata[15:8];
      2'd2:    lbyte = bus.mem_rdata[23:16];
      default: lbyte = bus.mem_rdata[31:24];
    endcase
    lhalf = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (f3_q[1:0])
      2'b00:   rdata_ext = {{24{~f3_q[2] & lbyte[7]}}, lbyte};
      2'b01:   rdata_ext = {{16{~f3_q[2] & lhalf[15]}}, lhalf};
      default: rdata_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    StallM    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: if (access && aligned) begin
        StallM    = 1'b1;
        issue     = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        StallM = 1'b1;
        if (bus.mem_ack || expired) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_be    <= '0;
      ReadDataM     <= '0;
      MisalignM     <= 1'b0;
      BusErrorM     <= 1'b0;
      cnt           <= '0;
      ld_q          <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
    end else begin
      MisalignM <= (state == IDLE) && access && !aligned;
      BusErrorM <= 1'b0;
      case (state)
        IDLE: if (issue) begin
          bus.mem_req   <= 1'b1;
          bus.mem_we    <= is_store;
          bus.mem_addr  <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
          bus.mem_be    <= be_nxt;
          bus.mem_wdata <= wdata_nxt;
          cnt           <= '0;
          ld_q          <= is_load;
          f3_q          <= AddressingControlM;
          off_q         <= off;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (ld_q) ReadDataM <= rdata_ext;
          end else if (expired) begin
            bus.mem_req <= 1'b0;
            BusErrorM   <= 1'b1;
            if (ld_q) ReadDataM <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a transaction-level expectation model checked
// every cycle, plus hand-computed literal expectations for each directed access.
module tb_mem_access_ctrl;
  localparam int TO = 4;

  logic        clk, rst_n;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [2:0]  AddressingControlM;
  logic        StallM, MisalignM, BusErrorM;
  logic [31:0] ReadDataM;

  mem_access_ctrl_if #(.DATA_WIDTH(32)) bus ();

  mem_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .AddressingControlM(AddressingControlM),
    .bus(bus.master), .StallM(StallM), .ReadDataM(ReadDataM),
    .MisalignM(MisalignM), .BusErrorM(BusErrorM)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Expected outputs for the current cycle, maintained by the stimulus.
  logic        exp_req, exp_we, exp_stall, exp_mis, exp_berr;
  logic [31:0] exp_addr, exp_wdata, exp_rd;
  logic [3:0]  exp_be;
  logic        cmp_en;

  int checks = 0;
  int fails  = 0;

  string       lit_name [256];
  logic [31:0] lit_act  [256];
  logic [31:0] lit_exp  [256];
  int          lit_n;
  int          lit_done = 0;

  typedef struct {
    int          stalls;
    int          reqs;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic        berr;
    logic        mis;
  } res_t;

  // ---- reference rules ----
  function automatic logic f_aligned(input logic [2:0] f3, input logic [31:0] a);
    if (f3 == 3'b000 || f3 == 3'b100) return 1'b1;
    if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) == 0;
    return (a % 4) == 0;
  endfunction

  function automatic logic [3:0] f_be(input logic st, input logic [2:0] f3, input logic [31:0] a);
    if (!st) return 4'hF;
    if (f3 == 3'b000) return 4'(1 << (a % 4));
    if (f3 == 3'b001) return ((a % 4) >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'b000) return (d & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'b001) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      v = (rd >> (8 * (a % 4))) & 32'hFF;
      if (f3 == 3'b000 && v >= 32'h80) v = v + 32'hFFFF_FF00;
      return v;
    end
    if (f3 == 3'b001 || f3 == 3'b101) begin
      v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32'h8000) v = v + 32'hFFFF_0000;
      return v;
    end
    return rd;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mem_req",   32'(bus.mem_req),  32'(exp_req));
      chk("mem_we",    32'(bus.mem_we),   32'(exp_we));
      chk("mem_addr",  bus.mem_addr,      exp_addr);
      chk("mem_be",    32'(bus.mem_be),   32'(exp_be));
      if (exp_req && exp_we) chk("mem_wdata", bus.mem_wdata, exp_wdata);
      chk("StallM",    32'(StallM),       32'(exp_stall));
      chk("ReadDataM", ReadDataM,         exp_rd);
      chk("MisalignM", 32'(MisalignM),    32'(exp_mis));
      chk("BusErrorM", 32'(BusErrorM),    32'(exp_berr));
    end
    while (lit_done < lit_n) begin
      chk(lit_name[lit_done], lit_act[lit_done], lit_exp[lit_done]);
      lit_done++;
    end
  end

  task automatic lit(input string n, input logic [31:0] act, input logic [31:0] exp);
    lit_name[lit_n] = n;
    lit_act[lit_n]  = act;
    lit_exp[lit_n]  = exp;
    lit_n++;
  endtask

  task automatic nop();
    MemWriteM = 1'b0; ResultSrcM = 2'b00; ALUResultM = '0;
    WriteDataM = '0; AddressingControlM = 3'b000;
  endtask

  // Entered and left at posedge+1 of an IDLE cycle. lat = WAIT cycle carrying ack (0 = never).
  task automatic access(input logic st, input logic ld, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int lat, output res_t r);
    logic store, load, err;
    int   end_k;
    store = st;
    load  = ld && !st;
    r = '{stalls: 0, reqs: 0, we: 1'b0, addr: '0, be: '0, wd: '0, berr: 1'b0, mis: 1'b0};
    MemWriteM = st; ResultSrcM = ld ? 2'b01 : 2'b00; ALUResultM = a;
    WriteDataM = wd; AddressingControlM = f3;
    if (!f_aligned(f3, a)) begin
      exp_stall = 1'b0;
      #1 r.stalls += int'(StallM); r.reqs += int'(bus.mem_req);
      @(posedge clk); #1;
      nop();
      exp_mis = 1'b1;
      #1 r.mis = MisalignM; r.reqs += int'(bus.mem_req); r.stalls += int'(StallM);
      @(posedge clk); #1;
      exp_mis = 1'b0;
      return;
    end
    exp_stall = 1'b1;
    #1 r.stalls += int'(StallM);
    err   = !(lat >= 1 && lat <= TO);
    end_k = err ? TO : lat;
    for (int k = 1; k <= end_k; k++) begin
      @(posedge clk); #1;
      exp_req = 1'b1; exp_we = store; exp_addr = a & 32'hFFFF_FFFC;
      exp_be = f_be(store, f3, a); exp_wdata = f_wdata(f3, wd); exp_stall = 1'b1;
      bus.mem_ack   = (k == lat);
      bus.mem_rdata = (k == lat) ? rd : 32'hA5A5_A5A5;
      #1 r.stalls += int'(StallM); r.reqs += int'(bus.mem_req);
      if (k == 1) begin
        r.we = bus.mem_we; r.addr = bus.mem_addr; r.be = bus.mem_be; r.wd = bus.mem_wdata;
      end
    end
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hA5A5_A5A5;
    exp_req = 1'b0;
    if (!err) exp_we = 1'b0;
    exp_stall = 1'b0;
    if (load) exp_rd = err ? 32'h0 : f_load(f3, a, rd);
    exp_berr = err;
    #1 r.stalls += int'(StallM); r.berr = BusErrorM;
    @(posedge clk); #1;
    nop();
    exp_berr = 1'b0;
  endtask

  res_t r;

  initial begin
    lit_n = 0; cmp_en = 1'b0; rst_n = 1'b0;
    nop();
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hA5A5_A5A5;
    exp_req = 0; exp_we = 0; exp_stall = 0; exp_mis = 0; exp_berr = 0;
    exp_addr = 0; exp_wdata = 0; exp_rd = 0; exp_be = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; cmp_en = 1'b1;
    lit("rst_req", 32'(bus.mem_req), 32'h0);
    lit("rst_stall", 32'(StallM), 32'h0);
    lit("rst_rd", ReadDataM, 32'h0);
    @(posedge clk); #1;

    access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 3, r);
    lit("lw_stalls", 32'(r.stalls), 32'd4);
    lit("lw_addr", r.addr, 32'h100);
    lit("lw_be", 32'(r.be), 32'hF);
    lit("lw_we", 32'(r.we), 32'h0);
    lit("lw_rd", ReadDataM, 32'hDEAD_BEEF);

    access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1, r);
    lit("lb_stalls", 32'(r.stalls), 32'd2);
    lit("lb_rd", ReadDataM, 32'hFFFF_FF80);
    access(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1, r);
    lit("lbu_rd", ReadDataM, 32'h0000_0080);

    access(1'b1, 1'b0, 3'b001, 32'h22, 32'h1234_ABCD, 32'h0, 2, r);
    lit("sh_we", 32'(r.we), 32'h1);
    lit("sh_be", 32'(r.be), 32'hC);
    lit("sh_wd", r.wd, 32'hABCD_ABCD);
    lit("sh_addr", r.addr, 32'h20);
    lit("sh_rd_held", ReadDataM, 32'h0000_0080);

    access(1'b1, 1'b0, 3'b000, 32'h101, 32'h0000_00C3, 32'h0, 1, r);
    lit("sb_be", 32'(r.be), 32'h2);
    lit("sb_wd", r.wd, 32'hC3C3_C3C3);

    access(1'b1, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, 32'h1111_1111, 1, r);
    lit("both_we", 32'(r.we), 32'h1);
    lit("both_rd_held", ReadDataM, 32'h0000_0080);

    access(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 32'h0, 1, r);
    lit("lw_mis_req", 32'(r.reqs), 32'h0);
    lit("lw_mis_stall", 32'(r.stalls), 32'h0);
    lit("lw_mis_flag", 32'(r.mis), 32'h1);
    access(1'b1, 1'b0, 3'b001, 32'h23, 32'hFFFF_FFFF, 32'h0, 1, r);
    lit("sh_mis_req", 32'(r.reqs), 32'h0);
    lit("sh_mis_flag", 32'(r.mis), 32'h1);
    access(1'b0, 1'b1, 3'b011, 32'h102, 32'h0, 32'h0, 1, r);
    lit("f3_011_mis", 32'(r.mis), 32'h1);
    access(1'b0, 1'b1, 3'b110, 32'h104, 32'h0, 32'h55AA_55AA, 1, r);
    lit("f3_110_rd", ReadDataM, 32'h55AA_55AA);
    access(1'b0, 1'b1, 3'b101, 32'h106, 32'h0, 32'h9ABC_0000, 2, r);
    lit("lhu_rd", ReadDataM, 32'h0000_9ABC);

    access(1'b0, 1'b1, 3'b010, 32'h200, 32'h0, 32'h7777_7777, 0, r);
    lit("to_reqs", 32'(r.reqs), 32'd4);
    lit("to_berr", 32'(r.berr), 32'h1);
    lit("to_rd", ReadDataM, 32'h0);
    access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0, 32'h8001_7FFF, 4, r);
    lit("ack4_berr", 32'(r.berr), 32'h0);
    lit("ack4_rd", ReadDataM, 32'hFFFF_8001);

    // Reset while waiting on a load that never acks.
    MemWriteM = 1'b0; ResultSrcM = 2'b01; ALUResultM = 32'h300; AddressingControlM = 3'b010;
    exp_stall = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h300; exp_be = 4'hF; exp_stall = 1'b1;
    end
    rst_n = 1'b0;
    nop();
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_req = 0; exp_we = 0; exp_stall = 0; exp_mis = 0; exp_berr = 0;
    exp_addr = 0; exp_wdata = 0; exp_rd = 0; exp_be = 0;
    lit("rstw_req", 32'(bus.mem_req), 32'h0);
    lit("rstw_stall", 32'(StallM), 32'h0);
    lit("rstw_rd", ReadDataM, 32'h0);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 32'h1234_5678, 2, r);
    lit("post_rst_rd", ReadDataM, 32'h1234_5678);
    lit("post_rst_stalls", 32'(r.stalls), 32'd3);

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
